// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
// master = fetch side (req, addr out; ready, rdata in); slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage + IF/ID register: owns PC, fetches, resolves branch/jump targets.
// Ports: clk, rst (async high), imem (fetch_unit_if.master), ID_nostall,
//   ID_npcOp, ID_imm, ID_rs_val in; pc, IF_ID_pc4, IF_ID_instr, IF_ID_valid out.
// Macro FETCH_NO_DELAY_SLOT_EN: taken redirects squash the fetch (no delay slot).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         ID_nostall,
  input  logic [1:0]   ID_npcOp,
  input  logic [31:0]  ID_imm,
  input  logic [31:0]  ID_rs_val,
  output logic [31:0]  pc,
  output logic [31:0]  IF_ID_pc4,
  output logic [31:0]  IF_ID_instr,
  output logic         IF_ID_valid
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIR
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] instr_q;
  logic        valid_q;
`ifndef FETCH_NO_DELAY_SLOT_EN
  logic [31:0] pend_q;
`endif

  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        redirect;
  logic        unused_rs;

  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = valid_q & ID_nostall & (ID_npcOp != 2'b00);
  // jr/jalr targets are word aligned; low bits are dropped.
  assign unused_rs = ^ID_rs_val[1:0];

  always_comb begin
    tgt = pc_plus4;
    unique case (ID_npcOp)
      2'b00: tgt = pc_plus4;
      2'b01: tgt = pc4_q + (ID_imm << 2);
      2'b10: tgt = {ID_rs_val[31:2], 2'b00};
      2'b11: tgt = {pc4_q[31:28], instr_q[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      pc4_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
`ifndef FETCH_NO_DELAY_SLOT_EN
      pend_q  <= 32'd0;
`endif
    end else if (state_q == S_BOOT) begin
      state_q <= S_RUN;
      req_q   <= 1'b1;
    end else if (ID_nostall) begin
`ifdef FETCH_NO_DELAY_SLOT_EN
      state_q <= S_RUN;
      if (redirect) begin
        pc_q    <= tgt;
        pc4_q   <= 32'd0;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (imem.imem_ready) begin
        pc_q    <= pc_plus4;
        pc4_q   <= pc_plus4;
        instr_q <= imem.imem_rdata;
        valid_q <= 1'b1;
      end else begin
        pc4_q   <= 32'd0;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
`else
      if (imem.imem_ready) begin
        pc4_q   <= pc_plus4;
        instr_q <= imem.imem_rdata;
        valid_q <= 1'b1;
        state_q <= S_RUN;
        if (redirect)
          pc_q <= tgt;
        else if (state_q == S_REDIR)
          pc_q <= pend_q;
        else
          pc_q <= pc_plus4;
      end else begin
        pc4_q   <= 32'd0;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
        // Delay slot not yet fetched: park the target until it arrives.
        if (redirect) begin
          pend_q  <= tgt;
          state_q <= S_REDIR;
        end
      end
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign IF_ID_pc4      = pc4_q;
  assign IF_ID_instr    = instr_q;
  assign IF_ID_valid    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then random traffic
// checked against a transaction-level model of fetch and redirect.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        nostall;
  logic [1:0]  op;
  logic [31:0] imm;
  logic [31:0] rs;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        valid;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .ID_nostall  (nostall),
    .ID_npcOp    (op),
    .ID_imm      (imm),
    .ID_rs_val   (rs),
    .pc          (pc),
    .IF_ID_pc4   (pc4),
    .IF_ID_instr (instr),
    .IF_ID_valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: architectural view of fetch.
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_boot;
  logic [31:0] m_pend[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h3000;
    m_pc4 = 0;
    m_instr = 0;
    m_valid = 0;
    m_boot = 1;
    m_pend.delete();
  endtask

  function automatic logic [31:0] target(input logic [1:0] o,
    input logic [31:0] p4, input logic [31:0] ins,
    input logic [31:0] im, input logic [31:0] r);
    logic [31:0] t;
    t = 0;
    if (o == 2'd1) t = p4 + im * 4;
    if (o == 2'd2) t = r - (r % 4);
    if (o == 2'd3) t = (p4 & 32'hF000_0000) | ((ins % (1 << 26)) * 4);
    return t;
  endfunction

  task automatic cyc(input string tag);
    logic [31:0] n_pc, n_pc4, n_instr, t;
    logic        n_valid, redir;
    chk({tag, "_req"}, bus.imem_req, {31'd0, ~m_boot});
    chk({tag, "_addr"}, bus.imem_addr, m_pc);
    n_pc = m_pc; n_pc4 = m_pc4; n_instr = m_instr; n_valid = m_valid;
    if (m_boot) begin
      m_boot = 0;
    end else if (nostall) begin
      redir = m_valid && (op != 2'd0);
      t = target(op, m_pc4, m_instr, imm, rs);
`ifdef FETCH_NO_DELAY_SLOT_EN
      if (redir) begin
        n_pc = t; n_pc4 = 0; n_instr = 0; n_valid = 0;
      end else if (bus.imem_ready) begin
        n_pc = m_pc + 4; n_pc4 = m_pc + 4;
        n_instr = bus.imem_rdata; n_valid = 1;
      end else begin
        n_pc4 = 0; n_instr = 0; n_valid = 0;
      end
`else
      if (bus.imem_ready) begin
        n_pc4 = m_pc + 4; n_instr = bus.imem_rdata; n_valid = 1;
        if (redir) n_pc = t;
        else if (m_pend.size() > 0) n_pc = m_pend.pop_front();
        else n_pc = m_pc + 4;
      end else begin
        n_pc4 = 0; n_instr = 0; n_valid = 0;
        if (redir) m_pend.push_back(t);
      end
`endif
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pc4 = n_pc4; m_instr = n_instr; m_valid = n_valid;
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_pc4"}, pc4, m_pc4);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_valid"}, valid, {31'd0, m_valid});
  endtask

  task automatic drive(input logic ns, input logic rdy, input logic [1:0] o,
    input logic [31:0] im, input logic [31:0] r, input logic [31:0] d);
    nostall = ns;
    bus.imem_ready = rdy;
    op = o;
    imm = im;
    rs = r;
    bus.imem_rdata = d;
  endtask

  initial begin
    logic [31:0] r16;
    rst = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    m_reset();
    #12;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc4", pc4, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_req", bus.imem_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("boot");
    // Sequential A, B
    drive(1, 1, 0, 0, 0, 32'hA000_000A);
    cyc("seqA");
    chk("seqA_lit", instr, 32'hA000_000A);
    chk("seqA_pc4lit", pc4, 32'h3004);
    drive(1, 1, 0, 0, 0, 32'hB000_000B);
    cyc("seqB");
    chk("seqB_pclit", pc, 32'h3008);
    // beq taken, delay slot C at 3008
    drive(1, 1, 2'd1, 32'hFFFF_FFFE, 0, 32'hC000_000C);
    cyc("beq");
`ifndef FETCH_NO_DELAY_SLOT_EN
    chk("beq_pclit", pc, 32'h3000);
    chk("beq_slot", instr, 32'hC000_000C);
    // jr under 2-cycle stall
    drive(0, 1, 2'd2, 0, 32'h0000_4007, 32'hDEAD_0001);
    cyc("jr_st0");
    cyc("jr_st1");
    chk("jr_hold", pc, 32'h3000);
    drive(1, 1, 2'd2, 0, 32'h0000_4007, 32'h0800_1000);
    cyc("jr_go");
    chk("jr_pclit", pc, 32'h4004);
    // j with memory not ready for 3 cycles
    drive(1, 0, 2'd3, 0, 0, 0);
    cyc("j_w0");
    cyc("j_w1");
    cyc("j_w2");
    chk("j_hold", pc, 32'h4004);
    drive(1, 1, 2'd3, 0, 0, 32'hE000_000E);
    cyc("j_go");
    chk("j_pclit", pc, 32'h4000);
    // Park a redirect, then reset asynchronously mid-redirect
    drive(1, 0, 2'd1, 32'h10, 0, 0);
    cyc("mid");
`else
    chk("beq_pclit", pc, 32'h3000);
    chk("beq_squash", valid, 0);
`endif
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_pc", pc, 32'h3000);
    chk("arst_valid", valid, 0);
    chk("arst_req", bus.imem_req, 0);
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    cyc("boot2");
    for (int i = 0; i < 400; i++) begin
      r16 = $urandom;
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), {{16{r16[15]}}, r16[15:0]},
            $urandom, $urandom);
      cyc("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and drives instruction memory.
- Consumes the ID decoder's next-PC select and stall signals, and feeds the fetched instruction and PC+4 to ID.
- Computes the branch and jump targets itself from the IF/ID contents.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- ID_nostall  in  1  0 = ID holds (load-use hazard).
- ID_npcOp  in  2  00 = pc+4, 01 = branch target, 10 = register target, 11 = jump target.
- ID_imm  in  32  sign-extended 16-bit immediate of the ID instruction.
- ID_rs_val  in  32  forwarded rs value (jr/jalr target).
- pc  out  32  current fetch PC.
- IF_ID_pc4  out  32  PC+4 of the instruction in ID.
- IF_ID_instr  out  32  instruction in ID.
- IF_ID_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, any time, including mid-redirect) sets:
  - pc = RESET_PC, IF_ID_instr = NOP_INSTR, IF_ID_pc4 = 0, IF_ID_valid = 0.
  - pend_tgt = 0, state = S_BOOT, imem_req = 0.
- States:
  - S_BOOT: lasts one cycle after reset deasserts; imem_req = 0; nothing moves; goes to S_RUN.
  - S_RUN: normal fetch.
  - S_REDIR: a redirect has been accepted and its delay slot is still being fetched.
- In S_RUN and S_REDIR: imem_req = 1 and imem_addr = pc, both combinational.
- redirect = IF_ID_valid & ID_nostall & (ID_npcOp != 00).
- Targets:
  - 01: bpc = IF_ID_pc4 + (ID_imm << 2).
  - 10: rpc = {ID_rs_val[31:2], 2'b00}.
  - 11: jpc = {IF_ID_pc4[31:28], IF_ID_instr[25:0], 2'b00}.
- All adds are 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Architecture has a delay slot: the instruction at the fetch PC when a redirect is accepted always executes.
- ID_nostall = 0: pc, IF/ID, state and pend_tgt all hold. imem_rdata is discarded and re-fetched next cycle. ID_npcOp is ignored.
- ID_nostall = 1 and imem_ready = 1:
  - IF/ID <= {pc+4, imem_rdata, valid = 1}.
  - Next pc: redirect target if redirect; else pend_tgt if state = S_REDIR; else pc+4.
  - state <= S_RUN.
- ID_nostall = 1 and imem_ready = 0:
  - IF/ID <= bubble {0, NOP_INSTR, valid = 0}; pc holds.
  - If redirect: pend_tgt <= target and state <= S_REDIR.
- redirect and S_REDIR are mutually exclusive: IF/ID only holds bubbles while in S_REDIR.
- Latency: imem_rdata accepted in cycle N appears on IF_ID_* in cycle N+1. The redirect target is presented on imem_addr in the cycle after the delay slot is accepted.

Optional Feature:
- Macro FETCH_NO_DELAY_SLOT_EN.
- Defined:
  - A taken redirect squashes the instruction being fetched: IF/ID <= bubble and pc <= target in the same cycle, regardless of imem_ready.
  - S_REDIR and pend_tgt are never used.
- Undefined: delay-slot behaviour as described in Behaviour.

Test Plan:
- Reset sequence:
  - During rst: all outputs hold reset values.
  - First cycle after release: imem_req = 0.
  - Next cycle: imem_addr = 32'h3000.
- Sequential fetch: imem_ready = 1, nostall = 1, words A, B, C.
  - IF_ID_instr = A then B.
  - IF_ID_pc4 = 32'h3004 then 32'h3008.
  - pc goes 3000, 3004, 3008.
- beq taken:
  - Setup: IF_ID_pc4 = 32'h3008, npcOp = 01, ID_imm = 32'hFFFF_FFFE.
  - Delay slot at 32'h3008 is loaded into IF/ID.
  - Next pc = 32'h3000.
- jr under load-use stall:
  - Setup: npcOp = 10, ID_rs_val = 32'h0000_4007, nostall = 0 for 2 cycles.
  - pc and IF/ID hold.
  - Once nostall = 1: redirect fires and pc = 32'h4004 after the delay slot.
- Redirect with imem_ready = 0 for 3 cycles (npcOp = 11, IF_ID_instr[25:0] = 26'h000_1000):
  - state = S_REDIR; IF_ID_valid = 0 each of those cycles; pc holds.
  - When ready: delay slot enters ID and pc = 32'h0000_4000.
- FETCH_NO_DELAY_SLOT_EN defined, beq taken:
  - IF_ID_valid = 0 in the next cycle.
  - pc = target immediately.
  - Fetched word never appears on IF_ID_instr.
